// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider: controller state
// encoding and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_repsub_dp.sv
// Datapath of the repeated-subtraction divider. Holds the remainder (R),
// divisor (D) and quotient (Q) registers plus the divide-by-zero flag.
// It only reacts to the control strobes from the controller; it has no
// notion of which state the divider is in.
module div_repsub_dp
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    input  logic             loadR_i,
    input  logic             loadD_i,
    input  logic             clrQ_i,
    input  logic             setQ_i,
    input  logic             decR_i,
    input  logic             incQ_i,
    input  logic             setDbz_i,
    input  logic             clrDbz_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             divByZero_o,
    output logic             rGeD_o,
    output logic             dataZero_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] diff;

    assign diff = rem_q - div_q;

    // Next-state selection for every datapath register, driven purely by strobes
    always_comb begin
        rem_d = rem_q;
        div_d = div_q;
        quo_d = quo_q;
        dbz_d = dbz_q;

        if (loadR_i) begin
            rem_d = data_i;
        end else if (decR_i) begin
            rem_d = diff;
        end

        if (loadD_i) begin
            div_d = data_i;
        end

        if (setQ_i) begin
            quo_d = '1;
        end else if (clrQ_i) begin
            quo_d = '0;
        end else if (incQ_i) begin
            quo_d = quo_q + WIDTH'(1);
        end

        if (setDbz_i) begin
            dbz_d = 1'b1;
        end else if (clrDbz_i) begin
            dbz_d = 1'b0;
        end
    end

    // Register update with synchronous active-low reset clearing everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            div_q <= '0;
            quo_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
            quo_q <= quo_d;
            dbz_q <= dbz_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign divByZero_o = dbz_q;
    assign rGeD_o      = (rem_q >= div_q);
    assign dataZero_o  = (data_i == '0);

endmodule

// File: rtl/div_repsub.sv
// Top level of the repeated-subtraction divider. The dividend arrives on the
// start cycle and the divisor on the next cycle over the shared data_in bus;
// the controller here sequences the datapath until R drops below D.
module div_repsub
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    div_state_e state_q, state_d;

    logic loadR;
    logic loadD;
    logic clrQ;
    logic setQ;
    logic decR;
    logic incQ;
    logic setDbz;
    logic clrDbz;
    logic rGeD;
    logic dataZero;

    div_repsub_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (data_in),
        .loadR_i     (loadR),
        .loadD_i     (loadD),
        .clrQ_i      (clrQ),
        .setQ_i      (setQ),
        .decR_i      (decR),
        .incQ_i      (incQ),
        .setDbz_i    (setDbz),
        .clrDbz_i    (clrDbz),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .divByZero_o (div_by_zero),
        .rGeD_o      (rGeD),
        .dataZero_o  (dataZero)
    );

    // Controller state register; reset always returns to IDLE and aborts work
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes; a zero divisor short-cuts straight to DONE
    always_comb begin
        state_d = state_q;
        loadR   = 1'b0;
        loadD   = 1'b0;
        clrQ    = 1'b0;
        setQ    = 1'b0;
        decR    = 1'b0;
        incQ    = 1'b0;
        setDbz  = 1'b0;
        clrDbz  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    loadR   = 1'b1;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                loadD = 1'b1;
                if (dataZero) begin
                    setQ    = 1'b1;
                    setDbz  = 1'b1;
                    state_d = DONE;
                end else begin
                    clrQ    = 1'b1;
                    clrDbz  = 1'b1;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (rGeD) begin
                    decR = 1'b1;
                    incQ = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_div_repsub.sv
// Self-checking bench for div_repsub: directed corner cases plus randomized
// divisions, all compared against plain integer division.
module tb_div_repsub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int compared = 0;
    int mismatched = 0;

    div_repsub #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one division a/b from the current IDLE cycle (T0) and check results
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit holdStart);
        logic [W-1:0] expQ;
        logic [W-1:0] expR;
        logic         expZ;
        int           lat;
        int           cyc;
        if (b == 0) begin
            expQ = {W{1'b1}};
            expR = a;
            expZ = 1'b1;
            lat  = 2;
        end else begin
            expQ = a / b;
            expR = a % b;
            expZ = 1'b0;
            lat  = 3 + int'(a / b);
        end
        start   = 1'b1;
        data_in = a;
        checkOutput("busyAtT0", busy, 0);
        tick();
        cyc     = 1;
        start   = holdStart;
        data_in = b;
        checkOutput("busyAtT1", busy, 1);
        checkOutput("doneAtT1", done, 0);
        while (!done && cyc < lat + 8) begin
            tick();
            cyc++;
            data_in = W'($urandom);
        end
        checkOutput("latency", cyc, lat);
        checkOutput("quotient", quotient, expQ);
        checkOutput("remainder", remainder, expR);
        checkOutput("divByZero", div_by_zero, expZ);
        checkOutput("busyInDone", busy, 1);
        tick();
        checkOutput("doneAfterPulse", done, 0);
        checkOutput("busyInIdle", busy, 0);
        checkOutput("quotientHeld", quotient, expQ);
        checkOutput("remainderHeld", remainder, expR);
        checkOutput("divByZeroHeld", div_by_zero, expZ);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           sawDone;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstQuotient", quotient, 0);
        checkOutput("rstRemainder", remainder, 0);
        checkOutput("rstDivByZero", div_by_zero, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] directed cases");
        applyStimulus(16'd100, 16'd7, 1'b0);
        applyStimulus(16'd5, 16'd9, 1'b0);
        applyStimulus(16'd42, 16'd0, 1'b0);
        applyStimulus(16'd0, 16'd7, 1'b0);

        // Zero divisor result must not stick once a normal division follows
        applyStimulus(16'd3, 16'd3, 1'b0);

        // Start held for the whole operation: DONE-cycle start is ignored
        applyStimulus(16'd20, 16'd5, 1'b1);
        tick();
        checkOutput("holdRestartBusy", busy, 1);
        start   = 1'b0;
        rst_n   = 1'b0;
        tick();
        rst_n   = 1'b1;
        tick();

        // Reset mid-operation aborts without a done pulse
        sawDone = 0;
        start   = 1'b1;
        data_in = 16'd1000;
        tick();
        start   = 1'b0;
        data_in = 16'd3;
        for (int t = 1; t < 10; t++) begin
            tick();
            if (done) sawDone++;
        end
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        checkOutput("midRstNoDone", sawDone, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", done, 0);
        checkOutput("midRstQuotient", quotient, 0);
        checkOutput("midRstRemainder", remainder, 0);
        checkOutput("midRstDivByZero", div_by_zero, 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        applyStimulus(16'd9, 16'd4, 1'b0);

        $display("[TB] randomized cases");
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            if (i % 6 == 0) begin
                b = '0;
            end else if (i % 6 == 1) begin
                a = '0;
                b = W'($urandom_range(1, 65535));
            end else begin
                b = W'($urandom_range(int'(a >> 6) + 1, 65535));
            end
            applyStimulus(a, b, 1'b0);
        end

        $display("[TB] maximum quotient");
        applyStimulus(16'hFFFF, 16'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div_repsub.md
DIV_REPSUB -- requirements
Module: div_repsub

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 start  in  1  request a new division; sampled only in IDLE.
REQ-005 data_in  in  WIDTH  shared operand bus: dividend on start cycle, divisor on following cycle.
REQ-006 quotient  out  WIDTH  result quotient, valid from done pulse until next accepted start.
REQ-007 remainder  out  WIDTH  result remainder, same validity as quotient.
REQ-008 busy  out  1  high from cycle after accepted start through DONE state inclusive.
REQ-009 done  out  1  single-cycle pulse, result valid.
REQ-010 div_by_zero  out  1  set with done when divisor is 0; held with results.

Function
REQ-011 FSM states IDLE, LOAD_B, COMPUTE, DONE; exactly one active per cycle.
REQ-012 IDLE: start=1 -> capture data_in into remainder register R, go LOAD_B; else stay.
REQ-013 LOAD_B: capture data_in into divisor register D, clear quotient register Q; data_in==0 -> set div_by_zero, Q<=all-ones, go DONE; else clear div_by_zero, go COMPUTE.
REQ-014 COMPUTE: R>=D (unsigned) -> R<=R-D, Q<=Q+1, stay; R<D -> go DONE, registers unchanged.
REQ-015 DONE: done=1 for this cycle only, go IDLE unconditionally.
REQ-016 Comparison and subtraction unsigned, WIDTH bits; R never underflows, Q never wraps (max 2^WIDTH-1 at D=1).
REQ-017 Latency, start cycle = T0: done at T(3+q) for nonzero divisor, q = quotient; done at T2 for zero divisor.
REQ-018 start while busy ignored; data_in ignored in COMPUTE, DONE.
REQ-019 start high in DONE cycle not accepted; accepted earliest in following IDLE cycle.
REQ-020 quotient, remainder, div_by_zero driven directly from Q, R, flag registers; stable in IDLE after done.
REQ-021 Dividend 0 with nonzero divisor: Q=0, R=0, done at T3.

Reset
REQ-022 rst_n=0 at a clock edge -> state IDLE, Q=0, R=0, D=0, div_by_zero=0, done=0, busy=0, regardless of current state.
REQ-023 Reset mid-operation aborts division with no done pulse; start sampled only from first edge with rst_n=1.

Structure
REQ-024 Shared package div_pkg holds state encoding constants (IDLE, LOAD_B, COMPUTE, DONE) and default WIDTH.
REQ-025 One sub-module div_repsub_dp: R, D, Q registers, subtractor, R>=D comparator, D==0 detect; controller FSM in top level drives its load/clear/dec/inc controls.
REQ-026 Datapath has no state-dependent logic; all sequencing in the controller.

Verification
REQ-027 100/7: start T0 data_in=100, T1 data_in=7 -> done T17, quotient=14, remainder=2, div_by_zero=0.
REQ-028 5/9 -> done T3, quotient=0, remainder=5.
REQ-029 65535/1 -> done T65538, quotient=65535, remainder=0, no wrap.
REQ-030 42/0 -> done T2, div_by_zero=1, quotient=16'hFFFF, remainder=42.
REQ-031 1000/3 with rst_n=0 at T10 -> state IDLE, all outputs 0, no done; new 9/4 afterwards -> quotient=2, remainder=1.
REQ-032 start held high through entire 20/5 operation -> single done at T7, quotient=4, remainder=0, next operation begins only at IDLE after DONE.
